// File: rtl/sonar_scheduler.sv
// Round-robin scheduler for four ultrasonic rangefinders: fires one trigger
// at a time, times the synchronized echo pulse and reports one result per ping.
module sonar_scheduler #(
    parameter int unsigned TRIG_CYCLES    = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 3800000,
    parameter int unsigned GAP_CYCLES     = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [3:0]  sensor_mask,
    input  logic [3:0]  echo,
    output logic [3:0]  trig,
    output logic        busy,
    output logic        result_valid,
    output logic [1:0]  result_id,
    output logic [21:0] result_count,
    output logic        result_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        SETTLE
    } state_t;

    localparam logic [21:0] TRIG_LAST    = 22'(TRIG_CYCLES - 1);
    localparam logic [21:0] TIMEOUT_MAX  = 22'(TIMEOUT_CYCLES);
    localparam logic [21:0] TIMEOUT_LAST = 22'(TIMEOUT_CYCLES - 1);
    localparam logic [21:0] GAP_LAST     = 22'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  last_id_q, last_id_d;
    logic [21:0] cnt_q, cnt_d;
    logic [3:0]  trig_q, trig_d;
    logic        busy_q, busy_d;
    logic        rv_q, rv_d;
    logic [1:0]  rid_q, rid_d;
    logic [21:0] rcount_q, rcount_d;
    logic        rto_q, rto_d;
    logic [3:0]  echo_s1_q, echo_s1_d;
    logic [3:0]  echo_s2_q, echo_s2_d;

    logic [1:0]  cand;
    logic [1:0]  next_sel;
    logic        next_found;
    logic        echo_sel;

    assign echo_sel = echo_s2_q[sel_q];

    // Pick the first enabled sensor after last_id, wrapping 3 -> 0.
    always_comb begin
        cand       = '0;
        next_sel   = last_id_q;
        next_found = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = last_id_q + 2'(k);
            if (!next_found && sensor_mask[cand]) begin
                next_sel   = cand;
                next_found = 1'b1;
            end
        end
    end

    // Next-state logic for the ping FSM, synchronizers and registered outputs.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_id_d = last_id_q;
        cnt_d     = cnt_q;
        trig_d    = trig_q;
        rv_d      = 1'b0;
        rid_d     = rid_q;
        rcount_d  = rcount_q;
        rto_d     = rto_q;
        echo_s1_d = echo;
        echo_s2_d = echo_s1_q;

        case (state_q)
            IDLE: begin
                if (enable && (sensor_mask != '0)) begin
                    sel_d   = next_sel;
                    state_d = TRIG;
                    cnt_d   = '0;
                    trig_d  = 4'b0001 << next_sel;
                end
            end
            TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d = WAIT_RISE;
                    cnt_d   = '0;
                    trig_d  = '0;
                end else begin
                    cnt_d = cnt_q + 22'd1;
                end
            end
            WAIT_RISE: begin
                if (echo_sel) begin
                    // The rise cycle is itself the first high cycle of the
                    // echo, so the cleared count starts at one here.
                    state_d = MEASURE;
                    cnt_d   = 22'd1;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    rv_d     = 1'b1;
                    rid_d    = sel_q;
                    rcount_d = '0;
                    rto_d    = 1'b1;
                    state_d  = SETTLE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 22'd1;
                end
            end
            MEASURE: begin
                if (cnt_q == TIMEOUT_MAX) begin
                    rv_d     = 1'b1;
                    rid_d    = sel_q;
                    rcount_d = TIMEOUT_MAX;
                    rto_d    = 1'b1;
                    state_d  = SETTLE;
                    cnt_d    = '0;
                end else if (!echo_sel) begin
                    rv_d     = 1'b1;
                    rid_d    = sel_q;
                    rcount_d = cnt_q;
                    rto_d    = 1'b0;
                    state_d  = SETTLE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 22'd1;
                end
            end
            SETTLE: begin
                if (cnt_q == GAP_LAST) begin
                    state_d   = IDLE;
                    last_id_d = sel_q;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 22'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                trig_d  = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            last_id_q <= 2'd3;
            cnt_q     <= '0;
            trig_q    <= '0;
            busy_q    <= 1'b0;
            rv_q      <= 1'b0;
            rid_q     <= '0;
            rcount_q  <= '0;
            rto_q     <= 1'b0;
            echo_s1_q <= '0;
            echo_s2_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_id_q <= last_id_d;
            cnt_q     <= cnt_d;
            trig_q    <= trig_d;
            busy_q    <= busy_d;
            rv_q      <= rv_d;
            rid_q     <= rid_d;
            rcount_q  <= rcount_d;
            rto_q     <= rto_d;
            echo_s1_q <= echo_s1_d;
            echo_s2_q <= echo_s2_d;
        end
    end

    assign trig           = trig_q;
    assign busy           = busy_q;
    assign result_valid   = rv_q;
    assign result_id      = rid_q;
    assign result_count   = rcount_q;
    assign result_timeout = rto_q;

endmodule

// File: tb/tb_sonar_scheduler.sv
// Directed bench for sonar_scheduler with short timing parameters.
module tb_sonar_scheduler;

    localparam int unsigned TRIG = 10;
    localparam int unsigned TO   = 200;
    localparam int unsigned GAP  = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [3:0]  sensor_mask;
    logic [3:0]  echo;
    logic [3:0]  trig;
    logic        busy;
    logic        result_valid;
    logic [1:0]  result_id;
    logic [21:0] result_count;
    logic        result_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned cyc = 0;
    int unsigned rv_cyc = 0;

    typedef struct {
        logic [3:0] mask;
        int         dly;    // cycles after trig falls before echo rises
        int         len;    // echo high cycles (>= 1000 means held high)
        logic [3:0] noise;  // unselected echo lines held high
        logic [1:0] id;
        int         count;
        logic       to;
        int         lat;    // cycles from trig fall to result_valid
        int         gap;    // cycles from previous result to trig rise (0 = skip)
    } ping_t;

    ping_t tbl[8];

    sonar_scheduler #(
        .TRIG_CYCLES   (TRIG),
        .TIMEOUT_CYCLES(TO),
        .GAP_CYCLES    (GAP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .sensor_mask   (sensor_mask),
        .echo          (echo),
        .trig          (trig),
        .busy          (busy),
        .result_valid  (result_valid),
        .result_id     (result_id),
        .result_count  (result_count),
        .result_timeout(result_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check("trig_at_most_one", 32'($countones(trig) <= 1), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_trig"}, 32'(trig), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rv"}, 32'(result_valid), 32'd0);
        check({tag, "_id"}, 32'(result_id), 32'd0);
        check({tag, "_count"}, 32'(result_count), 32'd0);
        check({tag, "_to"}, 32'(result_timeout), 32'd0);
    endtask

    task automatic wait_trig(input string tag, output bit ok);
        int w;
        w = 0;
        while (trig == '0 && w < 400) begin
            step();
            w++;
        end
        ok = (trig != '0);
        check({tag, "_trig_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_trig_fall(input string tag, output int width);
        width = 0;
        while (trig != '0 && width < 100) begin
            step();
            width++;
        end
        check({tag, "_trig_width"}, 32'(width), 32'(TRIG));
    endtask

    task automatic run_ping(input int idx, input ping_t p);
        bit    ok;
        int    width;
        int    lat;
        string tag;
        tag = $sformatf("p%0d", idx);
        sensor_mask = p.mask;
        enable      = 1'b1;
        wait_trig(tag, ok);
        if (!ok) return;
        if (p.gap != 0) check({tag, "_gap"}, cyc - rv_cyc, 32'(p.gap));
        check({tag, "_trig_sel"}, 32'(trig), 32'(4'b0001 << p.id));
        wait_trig_fall(tag, width);
        lat = 0;
        while (lat < 600) begin
            echo = p.noise | ((lat >= p.dly && lat < p.dly + p.len) ? (4'b0001 << p.id) : 4'b0000);
            step();
            lat++;
            if (result_valid) break;
        end
        check({tag, "_rv_seen"}, 32'(result_valid), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(p.lat));
        check({tag, "_id"}, 32'(result_id), 32'(p.id));
        check({tag, "_count"}, 32'(result_count), 32'(p.count));
        check({tag, "_to"}, 32'(result_timeout), 32'(p.to));
        rv_cyc = cyc;
        if (p.len < 1000) echo = '0;
        else echo = 4'b0001 << p.id;
        step();
        check({tag, "_rv_pulse"}, 32'(result_valid), 32'd0);
        check({tag, "_count_hold"}, 32'(result_count), 32'(p.count));
    endtask

    initial begin
        bit    ok;
        bit    seen;
        int    width;
        int    lat;
        ping_t pd;

        //          mask     dly  len   noise    id  count to lat  gap
        tbl[0] = '{4'b0001, 20,  75,   4'b1110, 0,  75,   0, 98,  0};
        tbl[1] = '{4'b1011, 5,   30,   4'b0000, 1,  30,   0, 38,  51};
        tbl[2] = '{4'b1011, 0,   1,    4'b0000, 3,  1,    0, 4,   51};
        tbl[3] = '{4'b1011, 10,  199,  4'b0000, 0,  199,  0, 212, 51};
        tbl[4] = '{4'b0100, 0,   0,    4'b1011, 2,  0,    1, 200, 51};
        tbl[5] = '{4'b1000, 197, 5,    4'b0000, 3,  5,    0, 205, 51};
        tbl[6] = '{4'b1000, 198, 5,    4'b0000, 3,  0,    1, 200, 51};
        tbl[7] = '{4'b0010, 20,  1000, 4'b0000, 1,  200,  1, 223, 51};

        rst_n       = 1'b0;
        enable      = 1'b0;
        sensor_mask = '0;
        echo        = '0;
        step();
        step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) run_ping(i, tbl[i]);

        // Echo still held high: next ping starts after the quiet gap anyway.
        wait_trig("stuck_next", ok);
        check("stuck_next_gap", cyc - rv_cyc, 32'd51);
        check("stuck_next_sel", 32'(trig), 32'b0010);
        echo = '0;
        rst_n = 1'b0;
        step();
        check("rst_trig_drop", 32'(trig), 32'd0);
        rst_n = 1'b1;

        // enable and mask dropped while measuring: ping completes, then idle.
        sensor_mask = 4'b0001;
        enable      = 1'b1;
        wait_trig("mid", ok);
        check("mid_trig_sel", 32'(trig), 32'b0001);
        wait_trig_fall("mid", width);
        lat = 0;
        while (lat < 600) begin
            echo = (lat >= 5 && lat < 45) ? 4'b0001 : 4'b0000;
            if (lat == 15) begin
                enable      = 1'b0;
                sensor_mask = '0;
            end
            step();
            lat++;
            if (result_valid) break;
        end
        echo = '0;
        check("mid_rv_seen", 32'(result_valid), 32'd1);
        check("mid_lat", 32'(lat), 32'd48);
        check("mid_id", 32'(result_id), 32'd0);
        check("mid_count", 32'(result_count), 32'd40);
        check("mid_to", 32'(result_timeout), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (trig != '0) seen = 1'b1;
        end
        check("mid_no_trig", 32'(seen), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_count_hold", 32'(result_count), 32'd40);

        // Reset during MEASURE: no result, outputs cleared, lowest bit next.
        pd = '{4'b0110, 5, 10, 4'b0000, 1, 10, 0, 18, 0};
        run_ping(8, pd);
        wait_trig("rstm", ok);
        check("rstm_trig_sel", 32'(trig), 32'b0100);
        wait_trig_fall("rstm", width);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            echo = (i >= 3) ? 4'b0100 : 4'b0000;
            step();
            if (result_valid) seen = 1'b1;
        end
        rst_n = 1'b0;
        step();
        if (result_valid) seen = 1'b1;
        check_all_zero("rstm");
        rst_n = 1'b1;
        echo  = '0;
        lat = 0;
        while (trig == '0 && lat < 300) begin
            step();
            lat++;
            if (result_valid) seen = 1'b1;
        end
        check("rstm_no_rv", 32'(seen), 32'd0);
        check("rstm_first_sel", 32'(trig), 32'b0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
